// File: rtl/regfile_wb_arb_pkg.sv
// regfile_wb_arb_pkg: shared types and constants for the register-file
// write-back arbiter and its scoreboard.
//   DATA_W / ADDR_W / NUM_REGS : register-file geometry
//   reg_bus_t / ZERO_WORD      : data word type and its reset value
//   src_e                      : arbitration priority encoding (SRC_A / SRC_B)
package regfile_wb_arb_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   typedef logic [DATA_W-1:0] reg_bus_t;
   localparam reg_bus_t ZERO_WORD = 64'h0000_0000_0000_0000;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   // The requester that did not hold priority.
   function automatic src_e other_src(input src_e s);
      return (s == SRC_A) ? SRC_B : SRC_A;
   endfunction

endpackage

// File: rtl/regfile_wb_arb_scoreboard.sv
// wb_scoreboard: tracks registers with an outstanding long-latency write.
//   clk, rst             : clock, async active-low reset
//   iss_valid/iss_addr   : dispatch of a long-latency op; iss_ready = WAW stall
//   clr_ena/clr_addr     : long-latency write handshake retiring a register
//   q_addr1/q_addr2      : source queries; hazard1/hazard2 report pending writes
//   w_ena/w_addr         : write held in the output register (not yet committed)
//   busy                 : scoreboard vector, bit 0 hard-wired to 0
module wb_scoreboard
   import regfile_wb_arb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                iss_valid,
   input  logic [ADDR_W-1:0]   iss_addr,
   output logic                iss_ready,
   input  logic                clr_ena,
   input  logic [ADDR_W-1:0]   clr_addr,
   input  logic [ADDR_W-1:0]   q_addr1,
   input  logic [ADDR_W-1:0]   q_addr2,
   input  logic                w_ena,
   input  logic [ADDR_W-1:0]   w_addr,
   output logic                hazard1,
   output logic                hazard2,
   output logic [NUM_REGS-1:0] busy
);

   localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]   ADDR_X0  = {ADDR_W{1'b0}};

   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_nxt_s;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] clr_mask_s;
   logic                iss_ready_s;

   // A register is hazardous while it awaits a long-latency write or while a
   // write to it sits in the output register one cycle before commit. x0 never is.
   function automatic logic lookup(input logic [NUM_REGS-1:0] bv,
                                   input logic [ADDR_W-1:0]   q,
                                   input logic                we,
                                   input logic [ADDR_W-1:0]   wa);
      return (q != ADDR_X0) && (bv[q] || (we && (wa == q)));
   endfunction

   // WAW stall, set/clear masks and next busy vector; set is OR-ed in after
   // clear so a same-address set and clear leaves the bit set.
   always_comb begin
      iss_ready_s = (iss_addr == ADDR_X0) || !busy_r[iss_addr];
      set_mask_s  = (iss_valid && iss_ready_s) ? (ONE_HOT0 << iss_addr) : {NUM_REGS{1'b0}};
      clr_mask_s  = clr_ena ? (ONE_HOT0 << clr_addr) : {NUM_REGS{1'b0}};
      busy_nxt_s  = ((busy_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
   end

   // Busy-vector state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= {NUM_REGS{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign iss_ready = iss_ready_s;
   assign busy      = busy_r;
   assign hazard1   = lookup(busy_r, q_addr1, w_ena, w_addr);
   assign hazard2   = lookup(busy_r, q_addr2, w_ena, w_addr);

endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: shares the register file's single write port between a
// single-cycle requester (A) and a long-latency requester (B), with a
// scoreboard of outstanding B writes for hazard and WAW checks.
//   clk, rst                      : clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data : requester A write channel
//   b_valid/b_ready/b_addr/b_data : requester B write channel
//   iss_valid/iss_ready/iss_addr  : dispatch of ops to unit B
//   q_addr1/q_addr2, hazard1/2    : read-after-write hazard queries
//   w_ena/w_addr/w_data           : registered regfile write port
//   busy                          : scoreboard vector
module regfile_wb_arb
   import regfile_wb_arb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_data,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_data,
   input  logic                iss_valid,
   output logic                iss_ready,
   input  logic [ADDR_W-1:0]   iss_addr,
   input  logic [ADDR_W-1:0]   q_addr1,
   input  logic [ADDR_W-1:0]   q_addr2,
   output logic                hazard1,
   output logic                hazard2,
   output logic                w_ena,
   output logic [ADDR_W-1:0]   w_addr,
   output logic [DATA_W-1:0]   w_data,
   output logic [NUM_REGS-1:0] busy
);

   localparam logic [ADDR_W-1:0] ADDR_X0 = {ADDR_W{1'b0}};

   src_e                prio_r;
   src_e                prio_nxt_s;
   logic                a_ready_s;
   logic                b_ready_s;
   logic                a_hs_s;
   logic                b_hs_s;
   logic                w_ena_r;
   logic [ADDR_W-1:0]   w_addr_r;
   reg_bus_t            w_data_r;
   logic                w_ena_nxt_s;
   logic [ADDR_W-1:0]   w_addr_nxt_s;
   reg_bus_t            w_data_nxt_s;

   // Arbitration: an uncontended requester always wins; under contention the
   // priority holder wins and priority passes to the loser for next cycle.
   always_comb begin
      a_ready_s = !b_valid || (prio_r == SRC_A);
      b_ready_s = !a_valid || (prio_r == SRC_B);
      a_hs_s    = a_valid && a_ready_s;
      b_hs_s    = b_valid && b_ready_s;
      if (a_valid && b_valid) begin
         prio_nxt_s = other_src(prio_r);
      end else begin
         prio_nxt_s = prio_r;
      end
   end

   // Next write-port contents; x0 writes are accepted but never enabled.
   always_comb begin
      w_ena_nxt_s  = 1'b0;
      w_addr_nxt_s = w_addr_r;
      w_data_nxt_s = w_data_r;
      if (b_hs_s) begin
         w_ena_nxt_s  = (b_addr != ADDR_X0);
         w_addr_nxt_s = b_addr;
         w_data_nxt_s = b_data;
      end else if (a_hs_s) begin
         w_ena_nxt_s  = (a_addr != ADDR_X0);
         w_addr_nxt_s = a_addr;
         w_data_nxt_s = a_data;
      end else begin
         w_ena_nxt_s  = 1'b0;
      end
   end

   // Priority and output-register state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_r   <= SRC_B;
         w_ena_r  <= 1'b0;
         w_addr_r <= ADDR_X0;
         w_data_r <= ZERO_WORD;
      end else begin
         prio_r   <= prio_nxt_s;
         w_ena_r  <= w_ena_nxt_s;
         w_addr_r <= w_addr_nxt_s;
         w_data_r <= w_data_nxt_s;
      end
   end

   wb_scoreboard u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .clr_ena   (b_hs_s),
      .clr_addr  (b_addr),
      .q_addr1   (q_addr1),
      .q_addr2   (q_addr2),
      .w_ena     (w_ena_r),
      .w_addr    (w_addr_r),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .busy      (busy)
   );

   assign a_ready = a_ready_s;
   assign b_ready = b_ready_s;
   assign w_ena   = w_ena_r;
   assign w_addr  = w_addr_r;
   assign w_data  = w_data_r;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed scenarios for regfile_wb_arb with hand-computed
// expectations. Inputs change on the falling edge; registered outputs are
// sampled 1 time unit after the rising edge.
module tb_regfile_wb_arb;
   import regfile_wb_arb_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
   logic                a_ready, b_ready, iss_ready, hazard1, hazard2, w_ena;
   logic [ADDR_W-1:0]   a_addr = 5'd0, b_addr = 5'd0, iss_addr = 5'd0;
   logic [ADDR_W-1:0]   q_addr1 = 5'd0, q_addr2 = 5'd0, w_addr;
   logic [DATA_W-1:0]   a_data = 64'h0, b_data = 64'h0, w_data;
   logic [NUM_REGS-1:0] busy;
   logic                allow_unissued = 1'b0;
   int                  checks = 0;
   int                  errors = 0;

   regfile_wb_arb dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
      .q_addr1(q_addr1), .q_addr2(q_addr2), .hazard1(hazard1), .hazard2(hazard2),
      .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // B may only write registers that were issued to it.
   always @(posedge clk) begin
      if (rst && b_valid && b_ready && !allow_unissued && (b_addr != 5'd0) && !busy[b_addr])
         $error("protocol: B write to unissued register %0d", b_addr);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b0; a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hAA;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hBB;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL rst_w_ena: got %0b expected 0", w_ena); end
      checks++; if (w_addr !== 5'd0) begin errors++; $display("FAIL rst_w_addr: got %0d expected 0", w_addr); end
      checks++; if (w_data !== 64'h0) begin errors++; $display("FAIL rst_w_data: got %0h expected 0", w_data); end
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", busy); end
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL rst_iss_ready: got %0b expected 1", iss_ready); end
      @(negedge clk); a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
      @(negedge clk); a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h11;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready: got %0b expected 1", a_ready); end
      @(posedge clk); #1;
      checks++; if (w_ena !== 1'b1) begin errors++; $display("FAIL a_only_w_ena: got %0b expected 1", w_ena); end
      checks++; if (w_addr !== 5'd5) begin errors++; $display("FAIL a_only_w_addr: got %0d expected 5", w_addr); end
      checks++; if (w_data !== 64'h11) begin errors++; $display("FAIL a_only_w_data: got %0h expected 11", w_data); end
      @(negedge clk); a_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL idle_w_ena: got %0b expected 0", w_ena); end
      checks++; if (w_addr !== 5'd5) begin errors++; $display("FAIL idle_w_addr_hold: got %0d expected 5", w_addr); end
   endtask

   task automatic test_contention();
      logic [3:0] exp_b = 4'b0101;
      @(negedge clk); iss_valid = 1'b1; iss_addr = 5'd7;
      #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL iss7_ready: got %0b expected 1", iss_ready); end
      @(posedge clk); #1;
      checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL iss7_busy: got %0b expected 1", busy[7]); end
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd3; a_data = 64'hA3;
      b_valid = 1'b1; b_addr = 5'd7; b_data = 64'hB7;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         iss_valid = (i == 1); iss_addr = 5'd7;
         #1;
         checks++; if (b_ready !== exp_b[i]) begin errors++; $display("FAIL cont_b_ready[%0d]: got %0b expected %0b", i, b_ready, exp_b[i]); end
         checks++; if (a_ready !== !exp_b[i]) begin errors++; $display("FAIL cont_a_ready[%0d]: got %0b expected %0b", i, a_ready, !exp_b[i]); end
         @(posedge clk); #1;
         checks++; if (w_ena !== 1'b1) begin errors++; $display("FAIL cont_w_ena[%0d]: got %0b expected 1", i, w_ena); end
         checks++; if (w_addr !== (exp_b[i] ? 5'd7 : 5'd3)) begin errors++; $display("FAIL cont_w_addr[%0d]: got %0d expected %0d", i, w_addr, exp_b[i] ? 7 : 3); end
         checks++; if (w_data !== (exp_b[i] ? 64'hB7 : 64'hA3)) begin errors++; $display("FAIL cont_w_data[%0d]: got %0h", i, w_data); end
      end
      @(negedge clk); a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
      #1;
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL cont_busy: got %0h expected 0", busy); end
      @(posedge clk); #1;
      checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL cont_idle: got %0b expected 0", w_ena); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk); iss_valid = 1'b1; iss_addr = 5'd9; q_addr1 = 5'd9; q_addr2 = 5'd3;
      @(posedge clk);
      @(negedge clk); iss_valid = 1'b0;
      #1;
      checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sb_busy9: got %0b expected 1", busy[9]); end
      checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL sb_haz1_busy: got %0b expected 1", hazard1); end
      checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL sb_haz2: got %0b expected 0", hazard2); end
      b_valid = 1'b1; b_addr = 5'd9; b_data = 64'h99;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready: got %0b expected 1", b_ready); end
      @(posedge clk); #1;
      checks++; if (busy[9] !== 1'b0) begin errors++; $display("FAIL sb_busy9_clr: got %0b expected 0", busy[9]); end
      checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL sb_haz1_inflight: got %0b expected 1", hazard1); end
      checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL sb_haz2_inflight: got %0b expected 0", hazard2); end
      @(negedge clk); b_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL sb_haz1_done: got %0b expected 0", hazard1); end
   endtask

   task automatic test_waw();
      @(negedge clk); iss_valid = 1'b1; iss_addr = 5'd4;
      #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL waw_first: got %0b expected 1", iss_ready); end
      @(posedge clk);
      @(negedge clk); #1;
      checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL waw_stall1: got %0b expected 0", iss_ready); end
      @(posedge clk);
      @(negedge clk); b_valid = 1'b1; b_addr = 5'd4; b_data = 64'h44;
      #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL waw_b_ready: got %0b expected 1", b_ready); end
      checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL waw_no_bypass: got %0b expected 0", iss_ready); end
      @(posedge clk); #1;
      checks++; if (busy[4] !== 1'b0) begin errors++; $display("FAIL waw_busy4_clr: got %0b expected 0", busy[4]); end
      @(negedge clk); b_valid = 1'b0;
      #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL waw_released: got %0b expected 1", iss_ready); end
      @(posedge clk); #1;
      checks++; if (busy[4] !== 1'b1) begin errors++; $display("FAIL waw_reissue: got %0b expected 1", busy[4]); end
      @(negedge clk); iss_valid = 1'b0;
   endtask

   task automatic test_same_cycle();
      @(negedge clk); iss_valid = 1'b1; iss_addr = 5'd8;
      b_valid = 1'b1; b_addr = 5'd4; b_data = 64'h4444;
      @(posedge clk); #1;
      checks++; if (busy[8] !== 1'b1) begin errors++; $display("FAIL diff_set8: got %0b expected 1", busy[8]); end
      checks++; if (busy[4] !== 1'b0) begin errors++; $display("FAIL diff_clr4: got %0b expected 0", busy[4]); end
      @(negedge clk); allow_unissued = 1'b1; iss_addr = 5'd6; b_addr = 5'd6; b_data = 64'h66;
      #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL same_iss_ready: got %0b expected 1", iss_ready); end
      @(posedge clk); #1;
      checks++; if (busy[6] !== 1'b1) begin errors++; $display("FAIL same_set_wins: got %0b expected 1", busy[6]); end
      checks++; if (w_ena !== 1'b1 || w_addr !== 5'd6) begin errors++; $display("FAIL same_write: got ena=%0b addr=%0d expected ena=1 addr=6", w_ena, w_addr); end
   endtask

   task automatic test_x0();
      @(negedge clk); b_valid = 1'b0; iss_valid = 1'b0; allow_unissued = 1'b0;
      a_valid = 1'b1; a_addr = 5'd0; a_data = 64'hFF;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready: got %0b expected 1", a_ready); end
      @(posedge clk); #1;
      checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL x0_w_ena: got %0b expected 0", w_ena); end
      @(negedge clk); a_valid = 1'b0; iss_valid = 1'b1; iss_addr = 5'd0; q_addr1 = 5'd0; q_addr2 = 5'd0;
      #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready: got %0b expected 1", iss_ready); end
      checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin errors++; $display("FAIL x0_hazard: got %0b%0b expected 00", hazard1, hazard2); end
      @(posedge clk); #1;
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy0: got %0b expected 0", busy[0]); end
      @(negedge clk); iss_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk); iss_valid = 1'b1; iss_addr = 5'd2;
      a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h55;
      b_valid = 1'b1; b_addr = 5'd8; b_data = 64'h88;
      #1;
      checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL ar_pre_grant: got a=%0b b=%0b expected a=0 b=1", a_ready, b_ready); end
      @(posedge clk); #1;
      checks++; if (w_ena !== 1'b1 || w_addr !== 5'd8 || busy[2] !== 1'b1) begin errors++; $display("FAIL ar_pre_state: got ena=%0b addr=%0d busy2=%0b expected 1 8 1", w_ena, w_addr, busy[2]); end
      iss_valid = 1'b0; q_addr1 = 5'd2;
      #2 rst = 1'b0;
      #1;
      checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL ar_w_ena: got %0b expected 0", w_ena); end
      checks++; if (w_addr !== 5'd0 || w_data !== 64'h0) begin errors++; $display("FAIL ar_w_addr_data: got %0d/%0h expected 0/0", w_addr, w_data); end
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL ar_busy: got %0h expected 0", busy); end
      checks++; if (iss_ready !== 1'b1 || hazard1 !== 1'b0) begin errors++; $display("FAIL ar_iss_haz: got rdy=%0b haz=%0b expected 1 0", iss_ready, hazard1); end
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("FAIL ar_prio: got a=%0b b=%0b expected a=0 b=1", a_ready, b_ready); end
      @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (w_ena !== 1'b0 || busy !== 32'h0) begin errors++; $display("FAIL ar_post[%0d]: got ena=%0b busy=%0h expected 0 0", i, w_ena, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_scoreboard();
      test_waw();
      test_same_cycle();
      test_x0();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
